// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The PIPE_PERF_EN build option is applied in pipe_hazard_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN           = 1'b0,
        REDIRECT_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    // Integer x0 is hardwired, so it never creates a dependency; FP f0 is a real register.
    function automatic logic reg_match(
        input logic [4:0] src_addr,
        input logic       src_fp,
        input logic [4:0] dst_addr,
        input logic       dst_fp
    );
        logic hit_s;
        hit_s = (src_addr == dst_addr) && (src_fp == dst_fp) &&
                (src_fp || (src_addr != REG_ZERO));
        return hit_s;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator: decode sources against the load in EX.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_fp,
    input  logic       id_rs2_fp,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_memread,
    input  logic       ex_rd_fp,
    output logic       load_use
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Per-source hit qualified by whether decode actually reads that source.
    always_comb begin
        rs1_hit_s = id_use_rs1 && reg_match(id_rs1_addr, id_rs1_fp, ex_rd_addr, ex_rd_fp);
        rs2_hit_s = id_use_rs2 && reg_match(id_rs2_addr, id_rs2_fp, ex_rd_addr, ex_rd_fp);
        load_use  = ex_memread && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; outputs are Mealy (zero-cycle).
// Optional build macro PIPE_PERF_EN adds free-running stall/bubble/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_fp,
    input  logic       id_rs2_fp,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_memread,
    input  logic       ex_rd_fp,
    input  logic       ex_branch_taken,
    input  logic       im_busy,
    input  logic       dm_busy,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idexe_we,
    output logic       ifid_flush,
    output logic       ctrl_flush
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_bubble_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    ctrl_state_e state_r;
    ctrl_state_e next_state_s;
    logic        load_use_s;

    hazard_cmp u_hazard_cmp (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_fp   (id_rs1_fp),
        .id_rs2_fp   (id_rs2_fp),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd_addr  (ex_rd_addr),
        .ex_memread  (ex_memread),
        .ex_rd_fp    (ex_rd_fp),
        .load_use    (load_use_s)
    );

    // Enable/flush decode and next-state selection, in priority order.
    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idexe_we     = 1'b0;
        ifid_flush   = 1'b0;
        ctrl_flush   = 1'b0;
        next_state_s = state_r;
        if (!rst) begin
            next_state_s = RUN;
        end else if (dm_busy) begin
            // Whole front end frozen; a pending drop or a branch in EX waits it out.
            next_state_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_branch_taken && !im_busy) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idexe_we   = 1'b1;
                        ifid_flush = 1'b1;
                        ctrl_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        pc_we        = 1'b1;
                        idexe_we     = 1'b1;
                        ctrl_flush   = 1'b1;
                        next_state_s = REDIRECT_WAIT;
                    end else if (im_busy || load_use_s) begin
                        idexe_we   = 1'b1;
                        ctrl_flush = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idexe_we = 1'b1;
                    end
                end
                REDIRECT_WAIT: begin
                    if (im_busy) begin
                        idexe_we   = 1'b1;
                        ctrl_flush = 1'b1;
                    end else begin
                        // The fetch that just returned is from the wrong path.
                        pc_we        = 1'b1;
                        ifid_we      = 1'b1;
                        idexe_we     = 1'b1;
                        ifid_flush   = 1'b1;
                        ctrl_flush   = 1'b1;
                        next_state_s = RUN;
                    end
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef PIPE_PERF_EN
    // Performance counters; wrap naturally at 2^PERF_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt  <= {PERF_W{1'b0}};
            perf_bubble_cnt <= {PERF_W{1'b0}};
            perf_flush_cnt  <= {PERF_W{1'b0}};
        end else begin
            if (!pc_we) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_ONE;
            end else begin
                perf_stall_cnt <= perf_stall_cnt;
            end
            if (ctrl_flush) begin
                perf_bubble_cnt <= perf_bubble_cnt + PERF_ONE;
            end else begin
                perf_bubble_cnt <= perf_bubble_cnt;
            end
            if (ifid_flush) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_ONE;
            end else begin
                perf_flush_cnt <= perf_flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes expected enables/flushes, monitor compares.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_rs1_fp;
    logic       id_rs2_fp;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd_addr;
    logic       ex_memread;
    logic       ex_rd_fp;
    logic       ex_branch_taken;
    logic       im_busy;
    logic       dm_busy;
    logic       pc_we;
    logic       ifid_we;
    logic       idexe_we;
    logic       ifid_flush;
    logic       ctrl_flush;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_fp       (id_rs1_fp),
        .id_rs2_fp       (id_rs2_fp),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd_addr      (ex_rd_addr),
        .ex_memread      (ex_memread),
        .ex_rd_fp        (ex_rd_fp),
        .ex_branch_taken (ex_branch_taken),
        .im_busy         (im_busy),
        .dm_busy         (dm_busy),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idexe_we        (idexe_we),
        .ifid_flush      (ifid_flush),
        .ctrl_flush      (ctrl_flush)
`ifdef PIPE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word is {pc_we, ifid_we, idexe_we, ifid_flush, ctrl_flush}.
    task automatic vec(
        input string      name,
        input logic       r,
        input logic [4:0] rs1, input logic fp1, input logic use1,
        input logic [4:0] rs2, input logic fp2, input logic use2,
        input logic [4:0] rd,  input logic mr,  input logic rdfp,
        input logic       br,  input logic imb, input logic dmb,
        input logic [4:0] exp
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        id_rs1_addr     = rs1;
        id_rs1_fp       = fp1;
        id_use_rs1      = use1;
        id_rs2_addr     = rs2;
        id_rs2_fp       = fp2;
        id_use_rs2      = use2;
        ex_rd_addr      = rd;
        ex_memread      = mr;
        ex_rd_fp        = rdfp;
        ex_branch_taken = br;
        im_busy         = imb;
        dm_busy         = dmb;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [4:0] exp);
        vec(name, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic ctl(input string name, input logic r, input logic br, input logic imb,
                       input logic dmb, input logic [4:0] exp);
        vec(name, r, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
            br, imb, dmb, exp);
    endtask

    // Monitor: outputs are valid every cycle; sample mid-cycle away from the edge.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_we, ifid_we, idexe_we, ifid_flush, ctrl_flush};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got pc/ifid/idexe/ifflush/ctrlflush=%b expected %b",
                         e.name, act, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_fp = 1'b0;
        id_rs2_fp = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_rd_addr = 5'd0;
        ex_memread = 1'b0; ex_rd_fp = 1'b0; ex_branch_taken = 1'b0;
        im_busy = 1'b0; dm_busy = 1'b0;

        ctl("reset_hold", 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
        idle("first_run", 5'b11100);

        // Load-use hazards
        vec("lu_rs1_int", 1'b1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 5'b00101);
        vec("lu_cleared", 1'b1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 5'b11100);
        vec("lu_x0_int", 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 5'b11100);
        vec("lu_f0_fp", 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 5'b00101);
        vec("lu_file_mism", 1'b1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 5'b11100);
        vec("lu_rs2_unused", 1'b1, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 5'b11100);
        vec("lu_rs2_used", 1'b1, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 5'b00101);

        // Branch redirect, fetch ready
        ctl("br_fast", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111);
        idle("br_fast_after", 5'b11100);
        ctl("im_busy_run", 1'b1, 1'b0, 1'b1, 1'b0, 5'b00101);

        // Branch with fetch outstanding: three bubbles then the drop
        ctl("br_slow", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10101);
        ctl("rw_wait1_br_ign", 1'b1, 1'b1, 1'b1, 1'b0, 5'b00101);
        ctl("rw_wait2", 1'b1, 1'b0, 1'b1, 1'b0, 5'b00101);
        ctl("rw_drop", 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111);
        idle("rw_back_run", 5'b11100);

        // dm_busy defers the drop across im_busy falling
        ctl("br_slow2", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10101);
        ctl("rw_dm1", 1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);
        ctl("rw_dm2", 1'b1, 1'b0, 1'b1, 1'b1, 5'b00000);
        ctl("rw_dm3", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000);
        ctl("rw_dm4", 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000);
        ctl("rw_dm_drop", 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111);
        idle("rw_dm_run", 5'b11100);

        // Branch frozen by dm_busy, serviced when it falls
        ctl("br_dm_frozen", 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000);
        ctl("br_dm_serviced", 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111);

        // Reset while a drop is pending discards it
        ctl("br_slow3", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10101);
        ctl("rst_in_rw", 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
`ifdef PIPE_PERF_EN
        #1;
        checks++;
        if ((perf_stall_cnt | perf_bubble_cnt | perf_flush_cnt) !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0",
                     perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt);
        end
`endif
        ctl("rst_hold2", 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);
        idle("after_rst_run", 5'b11100);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
